// File: rtl/reset_sequencer.sv
// reset_sequencer: merges power-on, debounced button, software and watchdog
// reset sources into one registered active-low system reset. Every reset
// event holds o_rstn low for HOLD_CYCLES edges. o_cause records which source
// caused the most recent reset and survives the resets it generates.
module reset_sequencer #(
    parameter int HOLD_CYCLES     = 64,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WDT_TIMEOUT     = 65535
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_n,
    input  logic       i_sw_req,
    input  logic       i_wdt_en,
    input  logic       i_wdt_kick,
    output logic       o_rstn,
    output logic [1:0] o_cause,
    output logic       o_busy
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int WDT_W  = $clog2(WDT_TIMEOUT) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [1:0]        btn_sync_reg;
    logic [DEB_W-1:0]  deb_cnt_reg;
    logic              btn_armed_reg;
    logic [WDT_W-1:0]  wdt_cnt_reg;

    logic btn_sync;
    logic btn_qual;
    logic wdt_fire;
    logic trigger;

    assign btn_sync = btn_sync_reg[1];

    // A press qualifies once per arming: the counter sits at its last value
    // with the button still low, so a held button cannot fire twice.
    assign btn_qual = btn_armed_reg && !btn_sync && (deb_cnt_reg == DEB_LAST);

    // Timeout only counts as a trigger while running, enabled and unserviced.
    assign wdt_fire = (state_reg == ST_RUN) && i_wdt_en && !i_wdt_kick &&
                      (wdt_cnt_reg == WDT_LAST);

    assign trigger = wdt_fire || btn_qual || i_sw_req;

    // Two-flop synchronizer for the asynchronous button, preset to released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_sync_reg <= 2'b11;
        end else begin
            btn_sync_reg <= {btn_sync_reg[0], i_btn_n};
        end
    end

    // Debounce counter with saturation and re-arm on an observed release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            deb_cnt_reg   <= '0;
            btn_armed_reg <= 1'b1;
        end else if (btn_sync) begin
            deb_cnt_reg   <= '0;
            btn_armed_reg <= 1'b1;
        end else if (btn_qual) begin
            btn_armed_reg <= 1'b0;
        end else if (deb_cnt_reg != DEB_LAST) begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
    end

    // Watchdog counter: runs only in RUN with the enable set, else restarts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdt_cnt_reg <= '0;
        end else if ((state_reg != ST_RUN) || !i_wdt_en || i_wdt_kick || wdt_fire) begin
            wdt_cnt_reg <= '0;
        end else begin
            wdt_cnt_reg <= wdt_cnt_reg + WDT_W'(1);
        end
    end

    // Sequencer FSM with registered reset, busy and cause outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            o_rstn       <= 1'b0;
            o_busy       <= 1'b1;
            o_cause      <= CAUSE_POR;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    // Triggers are ignored here; the hold simply runs out.
                    if (hold_cnt_reg == HOLD_LAST) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_RUN;
                        o_rstn       <= 1'b1;
                        o_busy       <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (trigger) begin
                        state_reg    <= ST_HOLD;
                        hold_cnt_reg <= '0;
                        o_rstn       <= 1'b0;
                        o_busy       <= 1'b1;
                        if (wdt_fire) begin
                            o_cause <= CAUSE_WDT;
                        end else if (btn_qual) begin
                            o_cause <= CAUSE_BTN;
                        end else begin
                            o_cause <= CAUSE_SW;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with HOLD=8, DEBOUNCE=4, WDT=20.
// Per-cycle vectors are table driven; async reset behaviour is hand written.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       sw;
    logic       en;
    logic       kick;
    logic       rstn;
    logic       busy;
    logic [1:0] cause;

    int compared   = 0;
    int mismatched = 0;

    reset_sequencer #(
        .HOLD_CYCLES    (8),
        .DEBOUNCE_CYCLES(4),
        .WDT_TIMEOUT    (20)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn_n   (btn_n),
        .i_sw_req  (sw),
        .i_wdt_en  (en),
        .i_wdt_kick(kick),
        .o_rstn    (rstn),
        .o_cause   (cause),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // One row: inputs held for n cycles; outputs checked after every edge.
    typedef struct {
        logic       rst;
        logic       btn_n;
        logic       sw;
        logic       en;
        logic       kick;
        int         n;
        logic       exp_rstn;
        logic [1:0] exp_cause;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic b, input logic s, input logic e,
                       input logic k, input int n, input logic er,
                       input logic [1:0] ec, input string nm);
        vec_t v;
        v.rst = r; v.btn_n = b; v.sw = s; v.en = e; v.kick = k;
        v.n = n; v.exp_rstn = er; v.exp_cause = ec; v.name = nm;
        tbl.push_back(v);
    endtask

    // Compares {rstn, busy, cause}; busy is always the complement of rstn.
    task automatic check_out(input string nm, input logic er, input logic [1:0] ec);
        logic [3:0] act;
        logic [3:0] req;
        act = {rstn, busy, cause};
        req = {er, ~er, ec};
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: rstn/busy/cause got %b_%b_%b required %b_%b_%b",
                     nm, act[3], act[2], act[1:0], req[3], req[2], req[1:0]);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int edges;

        rst = 1'b1; btn_n = 1'b1; sw = 1'b0; en = 1'b0; kick = 1'b0;

        //   rst btn sw en kick  n  rstn cause    name
        // power-on: 8 edges low after deassertion, rise on the 8th
        add(1, 1, 0, 0, 0,  3, 0, 2'b00, "por_rst");
        add(0, 1, 0, 0, 0,  7, 0, 2'b00, "por_hold");
        add(0, 1, 0, 0, 0,  1, 1, 2'b00, "por_rise");
        add(0, 1, 0, 0, 0,  3, 1, 2'b00, "idle");
        // 3 synchronized low cycles: too short
        add(0, 0, 0, 0, 0,  3, 1, 2'b00, "btn_short");
        add(0, 1, 0, 0, 0,  6, 1, 2'b00, "btn_short_rel");
        // 10-cycle press: qualifies on the 6th low cycle
        add(0, 0, 0, 0, 0,  5, 1, 2'b00, "btn10_pre");
        add(0, 0, 0, 0, 0,  5, 0, 2'b01, "btn10_hold");
        add(0, 1, 0, 0, 0,  3, 0, 2'b01, "btn10_hold2");
        add(0, 1, 0, 0, 0,  3, 1, 2'b01, "btn10_run");
        // held through the end of HOLD: no second reset until re-press
        add(0, 0, 0, 0, 0,  5, 1, 2'b01, "held_pre");
        add(0, 0, 0, 0, 0,  8, 0, 2'b01, "held_hold");
        add(0, 0, 0, 0, 0,  7, 1, 2'b01, "held_run");
        add(0, 1, 0, 0, 0,  3, 1, 2'b01, "held_rel");
        add(0, 0, 0, 0, 0,  5, 1, 2'b01, "repress_pre");
        add(0, 0, 0, 0, 0,  8, 0, 2'b01, "repress_hold");
        add(0, 1, 0, 0, 0,  3, 1, 2'b01, "repress_run");
        // software pulse, second pulse mid-HOLD does not extend
        add(0, 1, 1, 0, 0,  1, 0, 2'b10, "sw_pulse");
        add(0, 1, 0, 0, 0,  2, 0, 2'b10, "sw_hold_a");
        add(0, 1, 1, 0, 0,  1, 0, 2'b10, "sw_mid_pulse");
        add(0, 1, 0, 0, 0,  4, 0, 2'b10, "sw_hold_b");
        add(0, 1, 0, 0, 0,  2, 1, 2'b10, "sw_run");
        // watchdog without kicks: fires on the 20th cycle in RUN
        add(0, 1, 0, 1, 0, 19, 1, 2'b10, "wdt_count");
        add(0, 1, 0, 1, 0,  8, 0, 2'b11, "wdt_hold");
        add(0, 1, 0, 1, 0,  1, 1, 2'b11, "wdt_rise");
        // kicks every 15 cycles keep it quiet
        add(0, 1, 0, 1, 0, 14, 1, 2'b11, "kick_gap1");
        add(0, 1, 0, 1, 1,  1, 1, 2'b11, "kick1");
        add(0, 1, 0, 1, 0, 14, 1, 2'b11, "kick_gap2");
        add(0, 1, 0, 1, 1,  1, 1, 2'b11, "kick2");
        add(0, 1, 0, 1, 0, 14, 1, 2'b11, "kick_gap3");
        add(0, 1, 0, 1, 1,  1, 1, 2'b11, "kick3");
        // enable dropped exactly at count 19
        add(0, 1, 0, 1, 0, 19, 1, 2'b11, "en_to19");
        add(0, 1, 0, 0, 0,  1, 1, 2'b11, "en_drop");
        add(0, 1, 0, 0, 0,  4, 1, 2'b11, "en_off");
        // button and software on the same edge: button wins
        add(0, 0, 0, 0, 0,  5, 1, 2'b11, "bs_pre");
        add(0, 0, 1, 0, 0,  1, 0, 2'b01, "bs_trig");
        add(0, 1, 0, 0, 0,  7, 0, 2'b01, "bs_hold");
        add(0, 1, 0, 0, 0,  3, 1, 2'b01, "bs_run");
        // watchdog, button and software together: watchdog wins
        add(0, 1, 0, 1, 0, 14, 1, 2'b01, "all_pre_a");
        add(0, 0, 0, 1, 0,  5, 1, 2'b01, "all_pre_b");
        add(0, 0, 1, 1, 0,  1, 0, 2'b11, "all_trig");
        add(0, 1, 0, 0, 0,  7, 0, 2'b11, "all_hold");
        add(0, 1, 0, 0, 0,  3, 1, 2'b11, "all_run");
        // i_rst at hold count 5 restarts a full hold and clears the cause
        add(0, 1, 1, 0, 0,  1, 0, 2'b10, "mid_trig");
        add(0, 1, 0, 0, 0,  5, 0, 2'b10, "mid_hold5");
        add(1, 1, 0, 0, 0,  2, 0, 2'b00, "mid_rst");
        add(0, 1, 0, 0, 0,  7, 0, 2'b00, "mid_rehold");
        add(0, 1, 0, 0, 0,  1, 1, 2'b00, "mid_rise");

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                @(negedge clk);
                rst = tbl[i].rst; btn_n = tbl[i].btn_n; sw = tbl[i].sw;
                en = tbl[i].en; kick = tbl[i].kick;
                @(posedge clk);
                #1;
                check_out($sformatf("%s[%0d]", tbl[i].name, c),
                          tbl[i].exp_rstn, tbl[i].exp_cause);
            end
            $display("vec %0d %s cycles=%0d rstn=%b busy=%b cause=%b",
                     i, tbl[i].name, tbl[i].n, rstn, busy, cause);
        end

        // Hand-written: software reset, then an asynchronous i_rst from RUN.
        @(negedge clk);
        sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
        k = 0;
        while (rstn !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_int("sw_release_edges", k, 8);
        check_out("sw_cause_after_run", 1'b1, 2'b10);
        $display("seq sw_restart edges=%0d cause=%b", k, cause);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst_no_edge", 1'b0, 2'b00);
        $display("seq async_rst rstn=%b busy=%b cause=%b", rstn, busy, cause);

        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (rstn !== 1'b1 && edges < 30);
        check_int("async_rst_hold_edges", edges, 8);
        check_out("async_rst_final", 1'b1, 2'b00);
        $display("seq async_release edges=%0d", edges);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 64: number of clock cycles o_rstn is held low per reset event; legal range >=2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive synchronized-low samples of i_btn_n needed to qualify a button press; legal range >=2.
REQ-003 Parameter WDT_TIMEOUT, default 65535: watchdog limit in cycles; legal range >=2.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 i_clk  input  1  system clock.
REQ-006 i_rst  input  1  asynchronous active-high power-on reset.
REQ-007 i_btn_n  input  1  external reset button, active-low, asynchronous to i_clk.
REQ-008 i_sw_req  input  1  software reset request, level sampled each cycle.
REQ-009 i_wdt_en  input  1  watchdog enable.
REQ-010 i_wdt_kick  input  1  watchdog service strobe.
REQ-011 o_rstn  output  1  registered active-low system reset, drives the downstream reset synchronizer's active-low async input.
REQ-012 o_cause  output  2  cause of last reset: 00 power-on, 01 button, 10 software, 11 watchdog.
REQ-013 o_busy  output  1  high while the sequencer is in state HOLD.

Function
REQ-014 The sequencer has two states: HOLD (o_rstn=0, o_busy=1) and RUN (o_rstn=1, o_busy=0).
REQ-015 The sequencer has a hold counter, width clog2(HOLD_CYCLES)+1. On each edge in HOLD it increments. When the count reaches HOLD_CYCLES-1, the same edge clears the counter and moves the sequencer to RUN. o_rstn is therefore low for exactly HOLD_CYCLES rising edges.
REQ-016 i_btn_n passes through a 2-flop synchronizer, preset to 1 (released) by i_rst. The debounce counter increments while the synchronized value is 0 and clears when it is 1. A press qualifies on the edge where the counter reaches DEBOUNCE_CYCLES-1.
REQ-017 After a qualified press, the counter saturates and no new press qualifies until the synchronized button has been observed high for at least one cycle (re-arm).
REQ-018 The watchdog counter behaviour:
  - It counts only in RUN with i_wdt_en=1.
  - It clears on i_wdt_kick, on i_wdt_en=0, and in HOLD.
  - A timeout trigger fires on the edge where the count reaches WDT_TIMEOUT-1 and no kick is present.
REQ-019 A trigger in RUN (qualified press, i_sw_req=1, or watchdog timeout) at edge N makes o_rstn=0 and o_busy=1 after edge N. o_cause updates on the same edge N.
REQ-020 If triggers occur simultaneously, o_cause priority is watchdog > button > software.
REQ-021 Triggers arriving while in HOLD are ignored: they do not extend the hold, do not change o_cause, and are not queued. The debounce counter still runs and re-arm tracking continues.
REQ-022 o_cause is reset only by i_rst. It retains its value through sequencer-generated resets so software can read it after restart.
REQ-023 A continuously asserted i_sw_req causes a new reset each time the sequencer returns to RUN. This is legal; software must deassert it.
REQ-024 o_rstn, o_busy and o_cause come directly from flops, with no combinational path from any input.

Reset
REQ-025 While i_rst=1, the outputs are forced asynchronously to these values: state=HOLD, hold counter=0, o_rstn=0, o_busy=1, o_cause=00, debounce counter=0, button re-arm flag set, watchdog counter=0.
REQ-026 On i_rst deassertion, the HOLD_CYCLES sequence of REQ-015 starts from count 0. An i_rst assertion at any time, including mid-HOLD, restarts the sequence from count 0.

Verification (bench uses HOLD_CYCLES=8, DEBOUNCE_CYCLES=4, WDT_TIMEOUT=20)
REQ-027 Power-on: i_rst=1 for 3 cycles, then 0, other inputs idle. Required: o_rstn=0 for exactly 8 rising edges after deassertion, then 1; o_cause=00; o_busy falls together with the o_rstn rise.
REQ-028 Button debounce:
  - i_btn_n low for 3 synchronized cycles, then high: no reset.
  - i_btn_n low for 10 cycles: exactly one 8-cycle reset, o_cause=01.
  - Button held low through the end of HOLD: no second reset until release and a new 4-cycle press.
REQ-029 Software request: 1-cycle i_sw_req pulse in RUN. Required: o_rstn low from the next edge for 8 cycles; o_cause=10. A second pulse mid-HOLD causes no extension.
REQ-030 Watchdog:
  - i_wdt_en=1 with no kicks: reset after 20 cycles in RUN, o_cause=11.
  - Kicks every 15 cycles: never resets.
  - i_wdt_en dropped at count 19: no reset.
REQ-031 Simultaneous events and mid-sequence reset:
  - Qualified press, i_sw_req and watchdog timeout on the same edge: o_cause=11.
  - i_rst asserted at hold count 5: o_rstn stays 0, o_cause=00, full 8-cycle hold restarts after deassertion.
